memory_access_controller: RTL
=============================

# memory_access_controller

Sequences every data-memory transaction requested by the control unit's MOV / R/W microcode lines and returns the MOC (memory operation complete) status the microsequencer waits on. It owns a byte-addressed, big-endian RAM with a programmable number of wait states. It latches address, size and write data from MAR/MDR at request time, performs the access, and holds MOC under a four-phase handshake. A side load port lets the bench or loader preload program and data bytes while the controller is idle.

## Interface
- ADDR_WIDTH, 8: address width; RAM depth is 2^ADDR_WIDTH bytes.
- WAIT_STATES, 2: extra cycles inserted before the access is performed (0 allowed).

- Clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  reset, synchronous, active-high; clock Clk.
- mov  in  1  memory operation valid (request), level-held by the control unit.
- rw  in  1  1 = read, 0 = write.
- size  in  2  00 byte, 01 halfword, 10 word; 11 is treated as word.
- address  in  ADDR_WIDTH  byte address (from MAR).
- data_in  in  32  write data (from MDR); byte uses [7:0], halfword uses [15:0].
- data_out  out  32  read data, zero-extended for byte/halfword.
- moc  out  1  operation complete, registered.
- busy  out  1  high in any state other than IDLE.
- align_err  out  1  set with moc when the completed request was misaligned.
- load_en  in  1  preload write strobe, honoured only in IDLE.
- load_addr  in  ADDR_WIDTH  preload byte address.
- load_byte  in  8  preload data.

## Operation
- States: IDLE, WAIT, DONE.
- IDLE: busy=0, moc=0.
  - If mov=1 at an edge: latch rw, size, address and data_in; load the wait counter with WAIT_STATES; clear align_err; go to WAIT.
  - If load_en=1 at an edge: write ram[load_addr]=load_byte. When load_en and mov coincide, the load is written first and the request is still accepted on the same edge.
  - load_en is ignored outside IDLE.
- WAIT: busy=1.
  - Counter nonzero: decrement.
  - Counter zero: perform the access on this edge, set moc=1, go to DONE.
  - mov dropping during WAIT does not cancel the request: an accepted request always completes.
- Alignment: word requires address[1:0]=0; halfword requires address[0]=0. A misaligned request performs no RAM read or write, sets data_out=0 and align_err=1, and completes with normal timing.
- Big-endian layout: for a word at A, ram[A] maps to bits 31:24 and ram[A+3] to bits 7:0. For a halfword at A, ram[A] maps to bits 15:8.
- Read: data_out is updated at the access edge and held until the next read access, misaligned completion or reset.
- Write: RAM is updated at the access edge; data_out is unchanged.
- DONE: moc=1, busy=1.
  - At an edge with mov=0: moc=0, align_err=0, go to IDLE.
  - At an edge with mov=1: stay in DONE. A new request needs mov to be seen low first.
- Reset, including mid-operation: state=IDLE, moc=0, busy=0, align_err=0, data_out=0, counter=0. RAM contents are preserved, not cleared; any in-flight access that has not reached its access edge is dropped.

## Timing
- Request sampled at edge k: the access and the moc rise happen at edge k+1+WAIT_STATES. With WAIT_STATES=2, moc is first visible after edge k+3.
- moc stays high for at least one cycle, and until mov is sampled low. It falls on the first edge where mov=0 in DONE.
- Minimum turnaround: the earliest next request is accepted on the edge after the return to IDLE.
- busy rises on edge k and falls together with moc.
- The load port has one-edge write latency. A read of the same byte issued on the same edge sees the new byte.

## Test plan
- Preload ram[0x10..0x13] = 0xDE, 0xAD, 0xBE, 0xEF; word read at 0x10 -> moc rises exactly 3 edges after acceptance, data_out=0xDEADBEEF, align_err=0.
- Byte write 0x5A at 0x21, then halfword read at 0x20 with ram[0x20]=0x11 -> data_out=0x0000115A. Then word read at 0x20 -> bits 23:16 = 0x5A.
- Word read at 0x12 -> no RAM access, data_out=0, align_err=1, moc after 3 edges. Halfword write at 0x13 -> RAM unchanged.
- Hold mov high for 5 cycles after moc -> moc stays high, with no second access. Drop mov at the access edge -> moc is a single-cycle pulse, then IDLE.
- Assert reset during WAIT of a write 0xCAFEF00D to 0x40 -> next cycle moc=0, busy=0, data_out=0, ram[0x40..0x43] unchanged. Prior preloaded bytes are still readable.
- WAIT_STATES=0 build: request at edge k -> moc after edge k+1. A load_en during DONE is ignored, verified by read-back.

Source files
------------

// File: rtl/memory_access_controller_if.sv
// Bus between the control unit's MOV/R/W microcode and the memory controller.
// master: control unit / loader side; slave: memory_access_controller.
interface memory_access_controller_if #(
    parameter int ADDR_WIDTH = 8
);
    logic                  mov;
    logic                  rw;
    logic [1:0]            size;
    logic [ADDR_WIDTH-1:0] address;
    logic [31:0]           data_in;
    logic [31:0]           data_out;
    logic                  moc;
    logic                  busy;
    logic                  align_err;
    logic                  load_en;
    logic [ADDR_WIDTH-1:0] load_addr;
    logic [7:0]            load_byte;

    modport master (
        output mov, rw, size, address, data_in,
        output load_en, load_addr, load_byte,
        input  data_out, moc, busy, align_err
    );

    modport slave (
        input  mov, rw, size, address, data_in,
        input  load_en, load_addr, load_byte,
        output data_out, moc, busy, align_err
    );
endinterface

// File: rtl/memory_access_controller.sv
// Data-memory sequencer: big-endian byte RAM, programmable wait states,
// MOC four-phase handshake, side preload port honoured only while idle.
// Ports: Clk, reset (sync, active-high), bus (slave modport of
// memory_access_controller_if: request, read data, status, preload).
module memory_access_controller #(
    parameter int ADDR_WIDTH  = 8,
    parameter int WAIT_STATES = 2
) (
    input logic                         Clk,
    input logic                         reset,
    memory_access_controller_if.slave   bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int CW    = (WAIT_STATES < 2) ? 1 : $clog2(WAIT_STATES + 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t                r_state;
    state_t                w_next;
    logic                  r_rw;
    logic [1:0]            r_size;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [31:0]           r_wdata;
    logic [CW-1:0]         r_cnt;
    logic                  r_align;
    logic [31:0]           r_dout;
    logic [7:0]            r_mem [DEPTH];

    logic                  w_accept;
    logic                  w_access;
    logic                  w_misalign;
    logic                  w_load;
    logic                  w_wr;
    logic [ADDR_WIDTH-1:0] w_a1;
    logic [ADDR_WIDTH-1:0] w_a2;
    logic [ADDR_WIDTH-1:0] w_a3;
    logic [31:0]           w_rdata;

    assign w_a1 = r_addr + ADDR_WIDTH'(1);
    assign w_a2 = r_addr + ADDR_WIDTH'(2);
    assign w_a3 = r_addr + ADDR_WIDTH'(3);

    // Size 11 behaves as a word everywhere, so size[1] selects word.
    assign w_misalign = r_size[1] ? (r_addr[1:0] != 2'b00)
                      : (r_size[0] & r_addr[0]);

    assign w_load = bus.load_en && (r_state == S_IDLE);
    assign w_wr   = w_access && !reset && !w_misalign && !r_rw;

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_access = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (bus.mov) begin
                    w_next   = S_WAIT;
                    w_accept = 1'b1;
                end
            end
            S_WAIT: begin
                if (r_cnt == '0) begin
                    w_next   = S_DONE;
                    w_access = 1'b1;
                end
            end
            S_DONE: begin
                if (!bus.mov) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_rdata = '0;
        unique case (r_size)
            2'b00:   w_rdata = {24'h0, r_mem[r_addr]};
            2'b01:   w_rdata = {16'h0, r_mem[r_addr], r_mem[w_a1]};
            default: w_rdata = {r_mem[r_addr], r_mem[w_a1],
                                r_mem[w_a2], r_mem[w_a3]};
        endcase
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_align <= 1'b0;
            r_dout  <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_cnt   <= CW'(WAIT_STATES);
                r_align <= 1'b0;
            end else if (r_state == S_WAIT && r_cnt != '0) begin
                r_cnt <= r_cnt - CW'(1);
            end
            if (w_access) begin
                if (w_misalign) begin
                    r_align <= 1'b1;
                    r_dout  <= '0;
                end else if (r_rw) begin
                    r_dout <= w_rdata;
                end
            end
            if (r_state == S_DONE && !bus.mov) r_align <= 1'b0;
        end
    end

    // Request fields are only consumed after acceptance, so no reset needed.
    always_ff @(posedge Clk) begin
        if (w_accept && !reset) begin
            r_rw    <= bus.rw;
            r_size  <= bus.size;
            r_addr  <= bus.address;
            r_wdata <= bus.data_in;
        end
    end

    // RAM survives reset; preload and access never share a state.
    always_ff @(posedge Clk) begin
        if (w_load) r_mem[bus.load_addr] <= bus.load_byte;
        if (w_wr) begin
            unique case (r_size)
                2'b00: r_mem[r_addr] <= r_wdata[7:0];
                2'b01: begin
                    r_mem[r_addr] <= r_wdata[15:8];
                    r_mem[w_a1]   <= r_wdata[7:0];
                end
                default: begin
                    r_mem[r_addr] <= r_wdata[31:24];
                    r_mem[w_a1]   <= r_wdata[23:16];
                    r_mem[w_a2]   <= r_wdata[15:8];
                    r_mem[w_a3]   <= r_wdata[7:0];
                end
            endcase
        end
    end

    assign bus.moc       = (r_state == S_DONE);
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.align_err = r_align;
    assign bus.data_out  = r_dout;
endmodule
